// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit: queue entry layout,
// opcode constants and immediate decoders used by the static predictor.
package ifu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_npc;
    } fq_entry_t;

    // Branches are identified by opcode[6:2]; JAL by the full 7-bit opcode.
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// ICache request/response and IDU handshake bundle for the fetch queue.
// master = fetch queue side, slave = the cache/decode side that faces it.
interface ifu_fetch_queue_if;
    logic [31:0] cache_addr;
    logic        cache_hit;
    logic [31:0] cache_inst;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred_taken;
    logic [31:0] out_pred_npc;

    modport master (
        output cache_addr,
        input  cache_hit,
        input  cache_inst,
        input  out_ready,
        output out_valid,
        output out_pc,
        output out_inst,
        output out_pred_taken,
        output out_pred_npc
    );

    modport slave (
        input  cache_addr,
        output cache_hit,
        output cache_inst,
        output out_ready,
        input  out_valid,
        input  out_pc,
        input  out_inst,
        input  out_pred_taken,
        input  out_pred_npc
    );
endinterface

// File: rtl/ifu_static_pred.sv
// Static next-PC predictor: backward-taken conditional branches, and JAL as
// taken when IFU_JAL_PRED_EN is defined; everything else falls through to pc+4.
module ifu_static_pred
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    output logic        taken,
    output logic [31:0] pnpc
);

    always_comb begin
        taken = 1'b0;
        pnpc  = pc + 32'd4;
        // A set sign bit means a negative offset, i.e. a loop back-edge.
        if (inst[6:2] == OP_BRANCH && inst[31]) begin
            taken = 1'b1;
            pnpc  = pc + imm_b(inst);
        end
`ifdef IFU_JAL_PRED_EN
        if (inst[6:0] == OP_JAL) begin
            taken = 1'b1;
            pnpc  = pc + imm_j(inst);
        end
`endif
    end

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch stage with an FQ_DEPTH-entry queue of {pc, inst, prediction} between
// ICache and decode; handles redirects on hit or with a miss outstanding.
// Optional JAL prediction via IFU_JAL_PRED_EN (see ifu_static_pred).
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter  logic [31:0] RESET_PC = 32'h8000_0000,
    parameter  int          FQ_DEPTH = 4,
    localparam int          PTR_W    = $clog2(FQ_DEPTH)
) (
    input  logic                clock,
    input  logic                reset,
    ifu_fetch_queue_if.master   fq_bus,
    input  logic                flush,
    input  logic [31:0]         flush_pc,
    output logic [PTR_W:0]      fq_count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FQ_DEPTH);

    logic [31:0]      fetch_pc_reg;
    logic [31:0]      redirect_pc_reg;
    logic             redirect_pending_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W:0]   count_reg;

    fq_entry_t fq_mem [FQ_DEPTH];
    fq_entry_t head_entry;
    fq_entry_t new_entry;

    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        pop;
    logic        enq;

    ifu_static_pred u_pred (
        .pc    (fetch_pc_reg),
        .inst  (fq_bus.cache_inst),
        .taken (pred_taken),
        .pnpc  (pred_npc)
    );

    assign head_entry = fq_mem[rd_ptr_reg];
    assign new_entry  = '{pc: fetch_pc_reg, inst: fq_bus.cache_inst,
                          pred_taken: pred_taken, pred_npc: pred_npc};

    assign fq_bus.cache_addr     = fetch_pc_reg;
    assign fq_bus.out_valid      = (count_reg != '0) & ~flush;
    assign fq_bus.out_pc         = head_entry.pc;
    assign fq_bus.out_inst       = head_entry.inst;
    assign fq_bus.out_pred_taken = head_entry.pred_taken;
    assign fq_bus.out_pred_npc   = head_entry.pred_npc;
    assign fq_count              = count_reg;

    assign pop = fq_bus.out_valid & fq_bus.out_ready;
    // A full queue still accepts when the head leaves in the same cycle.
    assign enq = fq_bus.cache_hit & ~flush & ~redirect_pending_reg &
                 ((count_reg != FULL_COUNT) | pop);

    always_ff @(posedge clock) begin
        if (enq) begin
            fq_mem[wr_ptr_reg] <= new_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_reg         <= RESET_PC;
            redirect_pc_reg      <= '0;
            redirect_pending_reg <= 1'b0;
            rd_ptr_reg           <= '0;
            wr_ptr_reg           <= '0;
            count_reg            <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            // Without a hit the cache is still busy with the old address, so
            // the new target has to wait until that response drains.
            if (fq_bus.cache_hit) begin
                fetch_pc_reg         <= flush_pc;
                redirect_pending_reg <= 1'b0;
            end else begin
                redirect_pending_reg <= 1'b1;
                redirect_pc_reg      <= flush_pc;
            end
        end else begin
            if (enq) begin
                wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
                fetch_pc_reg <= pred_npc;
            end else if (redirect_pending_reg && fq_bus.cache_hit) begin
                fetch_pc_reg         <= redirect_pc_reg;
                redirect_pending_reg <= 1'b0;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
        end
    end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: streaming, backpressure, prediction,
// flush on hit, flush during a miss, and JAL prediction (IFU_JAL_PRED_EN aware).
module tb_ifu_fetch_queue;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BEQ_BACK = 32'hFE00_0CE3;
    localparam logic [31:0] JAL_16   = 32'h0100_006F;
    localparam logic [31:0] NOWHERE  = 32'hFFFF_FFF0;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] flush_pc;
    logic [2:0]  fq_count;
    logic [31:0] beq_at;
    logic [31:0] jal_at;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_fetch_queue_if bus ();

    ifu_fetch_queue dut (
        .clock    (clock),
        .reset    (reset),
        .fq_bus   (bus.master),
        .flush    (flush),
        .flush_pc (flush_pc),
        .fq_count (fq_count)
    );

    always #5 clock = ~clock;

    // Minimal ICache model: instruction chosen by address.
    always_comb begin
        bus.cache_inst = NOP;
        if (bus.cache_addr == beq_at) bus.cache_inst = BEQ_BACK;
        if (bus.cache_addr == jal_at) bus.cache_inst = JAL_16;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        flush         = 1'b0;
        flush_pc      = '0;
        bus.cache_hit = 1'b0;
        bus.out_ready = 1'b0;
        beq_at        = NOWHERE;
        jal_at        = NOWHERE;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [31:0] exp_jal_npc;
    logic        exp_jal_taken;

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("rst_count", {29'b0, fq_count}, 32'd0);
        check_eq("rst_addr", bus.cache_addr, 32'h8000_0000);

        // Streaming with an always-hitting cache
        bus.cache_hit = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check_eq("stream_valid_c1", {31'b0, bus.out_valid}, 32'd0);
        tick();
        check_eq("stream_valid_c2", {31'b0, bus.out_valid}, 32'd1);
        check_eq("stream_pc0", bus.out_pc, 32'h8000_0000);
        tick();
        check_eq("stream_pc1", bus.out_pc, 32'h8000_0004);
        tick();
        check_eq("stream_pc2", bus.out_pc, 32'h8000_0008);
        check_eq("stream_count", {29'b0, fq_count}, 32'd1);

        // Backpressure: fill, stall, simultaneous pop+enq on full, then drain
        do_reset();
        bus.cache_hit = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_eq("full_count", {29'b0, fq_count}, 32'd4);
        check_eq("full_addr", bus.cache_addr, 32'h8000_0010);
        bus.out_ready = 1'b1;
        tick();
        check_eq("full_popenq_count", {29'b0, fq_count}, 32'd4);
        check_eq("full_popenq_addr", bus.cache_addr, 32'h8000_0014);
        bus.cache_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_valid", {31'b0, bus.out_valid}, 32'd1);
            check_eq("drain_pc", bus.out_pc, 32'h8000_0004 + 32'(4 * i));
            tick();
        end
        check_eq("drain_empty", {31'b0, bus.out_valid}, 32'd0);

        // Backward beq predicted taken
        do_reset();
        beq_at        = 32'h8000_0008;
        bus.cache_hit = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        check_eq("beq_pc", bus.out_pc, 32'h8000_0008);
        check_eq("beq_inst", bus.out_inst, BEQ_BACK);
        check_eq("beq_taken", {31'b0, bus.out_pred_taken}, 32'd1);
        check_eq("beq_npc", bus.out_pred_npc, 32'h8000_0000);
        check_eq("beq_next_addr", bus.cache_addr, 32'h8000_0000);
        beq_at = NOWHERE;
        tick();
        check_eq("beq_target_pc", bus.out_pc, 32'h8000_0000);
        check_eq("nop_taken", {31'b0, bus.out_pred_taken}, 32'd0);
        check_eq("nop_npc", bus.out_pred_npc, 32'h8000_0004);

        // Flush with three entries queued and a hit
        do_reset();
        bus.cache_hit = 1'b1;
        tick();
        tick();
        tick();
        check_eq("preflush_count", {29'b0, fq_count}, 32'd3);
        flush    = 1'b1;
        flush_pc = 32'h8000_0100;
        #1;
        check_eq("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        tick();
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        check_eq("postflush_count", {29'b0, fq_count}, 32'd0);
        check_eq("postflush_addr", bus.cache_addr, 32'h8000_0100);
        tick();
        check_eq("postflush_pc", bus.out_pc, 32'h8000_0100);

        // Flush during a miss, overwritten by a second flush before the hit
        do_reset();
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        flush_pc      = 32'h8000_0100;
        tick();
        flush = 1'b0;
        tick();
        check_eq("miss_addr_held", bus.cache_addr, 32'h8000_0000);
        flush    = 1'b1;
        flush_pc = 32'h8000_0200;
        tick();
        flush = 1'b0;
        tick();
        bus.cache_hit = 1'b1;
        tick();
        check_eq("miss_discard_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("miss_discard_count", {29'b0, fq_count}, 32'd0);
        check_eq("miss_redirect_addr", bus.cache_addr, 32'h8000_0200);
        tick();
        check_eq("miss_redirect_pc", bus.out_pc, 32'h8000_0200);

        // JAL +16 at the reset PC
`ifdef IFU_JAL_PRED_EN
        exp_jal_npc   = 32'h8000_0010;
        exp_jal_taken = 1'b1;
`else
        exp_jal_npc   = 32'h8000_0004;
        exp_jal_taken = 1'b0;
`endif
        do_reset();
        jal_at        = 32'h8000_0000;
        bus.cache_hit = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check_eq("jal_taken", {31'b0, bus.out_pred_taken}, {31'b0, exp_jal_taken});
        check_eq("jal_npc", bus.out_pred_npc, exp_jal_npc);
        tick();
        check_eq("jal_next_pc", bus.out_pc, exp_jal_npc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Parametrised successor to the single-entry fetch stage.
- Drives a combinational-hit instruction cache lookup and predicts the next PC statically.
- Buffers fetched {pc, inst, prediction} in a FIFO of FQ_DEPTH entries so cache fetch continues while decode stalls.
- Sits between the ICache and the IDU. Handles redirects (jump/CSR flush) both on a hit and while a miss is outstanding.

Parameters:
- RESET_PC, 32'h8000_0000, first fetch address after reset (SoC build overrides with 32'h3000_0000).
- FQ_DEPTH, 4, fetch queue entries; power of two, minimum 2.
- PTR_W, $clog2(FQ_DEPTH), read/write pointer width (derived, not overridden).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cache_addr  out  32  fetch address to ICache; held stable while cache_hit=0
- cache_hit  in  1  cache_inst valid for cache_addr this cycle
- cache_inst  in  32  instruction at cache_addr
- flush  in  1  redirect request (parent merges jump/CSR flush, CSR has priority)
- flush_pc  in  32  redirect target, valid with flush
- out_ready  in  1  IDU accepts
- out_valid  out  1  queue head valid
- out_pc  out  32  head PC
- out_inst  out  32  head instruction
- out_pred_taken  out  1  head was predicted taken
- out_pred_npc  out  32  head predicted next PC
- fq_count  out  PTR_W+1  current occupancy

Behaviour:
- Reset: fetch_pc=RESET_PC, queue empty (rd_ptr=wr_ptr=0, count=0), redirect_pending=0, out_valid=0, fq_count=0.
- out_valid = (count!=0) & ~flush. Head fields are driven from the rd_ptr entry; their value is don't-care when out_valid=0.
- Pop = out_valid & out_ready: rd_ptr+1 (wraps modulo FQ_DEPTH).
- Enqueue allowed when cache_hit & ~flush & ~redirect_pending & (count<FQ_DEPTH | pop).
  - Enqueue writes {fetch_pc, cache_inst, taken, pnpc} and sets fetch_pc<=pnpc.
  - A full queue with a simultaneous pop accepts the new entry in the same cycle.
- Stall: hit while the queue is full and there is no pop → no enqueue, fetch_pc held.
- Prediction, combinational on cache_inst:
  - opcode[6:2]=5'b11000 (branch) with inst[31]=1 → taken; pnpc = fetch_pc + sext(imm_b).
  - Otherwise pnpc = fetch_pc + 4.
  - 32-bit add, wraps modulo 2^32.
- Flush, cycle N:
  - Queue cleared (count<=0, pointers reset to 0). No handshake occurs in cycle N.
  - If cache_hit=1 or idle: the fetched inst is discarded and fetch_pc<=flush_pc.
  - If cache_hit=0 (miss in flight): redirect_pending<=1, redirect_pc<=flush_pc, fetch_pc held.
- Redirect pending:
  - On the first cache_hit, discard the instruction, set fetch_pc<=redirect_pc and clear pending.
  - A further flush while pending overwrites redirect_pc.
- Count update: count + enq - pop, or 0 on flush.
- Reset mid-miss: state returns to reset values. The cache owns its own reset.

Optional Feature:
- Macro IFU_JAL_PRED_EN.
- Defined: opcode 7'b1101111 (JAL) is also predicted taken, with pnpc = fetch_pc + sext(imm_j).
- Undefined: JAL falls through to pc+4 and relies on the EXU flush.
- The branch prediction rule is unchanged either way.

Decomposition:
- Shared package ifu_pkg holds:
  - typedef fq_entry_t {pc, inst, pred_taken, pred_npc}
  - opcode constants OP_BRANCH, OP_JAL
  - functions imm_b(), imm_j()
- Natural sub-module: ifu_static_pred (combinational inst+pc → taken, pnpc), instantiated once.
- The FIFO storage stays inline.

Test Plan:
- Reset, cache always hit with inst=32'h00000013, out_ready=1 → out_pc sequence 0x80000000, 0x80000004, 0x80000008, first out_valid on cycle 2.
- out_ready=0, cache hitting → fq_count reaches 4 and stays; fetch_pc frozen at 0x80000010; release → 4 pops in 4 consecutive cycles with no bubble.
- Backward beq at 0x80000008 (inst 32'hFE000CE3, imm -8) → out_pred_taken=1, out_pred_npc=0x80000000, next fetched pc 0x80000000.
- flush=1, flush_pc=0x80000100 with 3 queued entries and hit → out_valid=0 that cycle, fq_count=0 next cycle, next out_pc=0x80000100.
- flush during a 5-cycle miss, then a second flush to 0x80000200 before the hit → miss data discarded; next cache_addr=0x80000200.
- IFU_JAL_PRED_EN defined, jal +16 at 0x80000000 → out_pred_npc=0x80000010. Undefined → 0x80000004.
